// File: rtl/rtc_calendar.sv
// Real-time clock with Gregorian calendar, validated time/date load and a
// time-of-day alarm. The prescaler turns clk into a one-second tick.
module rtc_calendar #(
   parameter int PRESCALE   = 32768,
   parameter int YEAR_BASE  = 2000,
   parameter int YEAR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [5:0]            set_sec,
   input  logic [5:0]            set_min,
   input  logic [4:0]            set_hour,
   input  logic [4:0]            set_day,
   input  logic [3:0]            set_month,
   input  logic [YEAR_WIDTH-1:0] set_year,
   input  logic                  alarm_en,
   input  logic [5:0]            alarm_sec,
   input  logic [5:0]            alarm_min,
   input  logic [4:0]            alarm_hour,
   output logic [5:0]            sec,
   output logic [5:0]            minute,
   output logic [4:0]            hour,
   output logic [4:0]            day,
   output logic [3:0]            month,
   output logic [YEAR_WIDTH-1:0] year,
   output logic                  tick_1hz,
   output logic                  set_err,
   output logic                  alarm_irq
);

   localparam int CNT_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam int NYEARS = 2 ** YEAR_WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

   // Leap flags for every representable year, folded to constants at elaboration.
   function automatic logic [NYEARS-1:0] build_leap_map();
      logic [NYEARS-1:0] map;
      int                y;
      map = '0;
      for (int i = 0; i < NYEARS; i++) begin
         y      = YEAR_BASE + i;
         map[i] = ((y % 4) == 0) && !(((y % 100) == 0) && ((y % 400) != 0));
      end
      return map;
   endfunction

   localparam logic [NYEARS-1:0] LEAP_MAP = build_leap_map();

   function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
      logic [4:0] len;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
         4'd2:                    len = leap ? 5'd29 : 5'd28;
         default:                 len = 5'd31;
      endcase
      return len;
   endfunction

   logic [CNT_W-1:0]      cnt;
   logic                  tick;
   logic                  set_valid;
   logic                  alarm_match;
   logic [4:0]            cur_mlen;
   logic [4:0]            set_mlen;
   logic [5:0]            nxt_sec;
   logic [5:0]            nxt_min;
   logic [4:0]            nxt_hour;
   logic [4:0]            nxt_day;
   logic [3:0]            nxt_month;
   logic [YEAR_WIDTH-1:0] nxt_year;

   assign tick        = (cnt == CNT_MAX);
   assign cur_mlen    = month_len(month, LEAP_MAP[year]);
   assign set_mlen    = month_len(set_month, LEAP_MAP[set_year]);
   assign alarm_match = (sec == alarm_sec) && (minute == alarm_min) && (hour == alarm_hour);

   assign set_valid = (set_sec <= 6'd59) && (set_min <= 6'd59) && (set_hour <= 5'd23) &&
                      (set_month >= 4'd1) && (set_month <= 4'd12) &&
                      (set_day >= 5'd1) && (set_day <= set_mlen);

   // Full carry chain evaluated in one pass so every field updates on the same edge.
   always_comb begin
      // NOTE: every output of this block gets a default first, otherwise the
      // nested ifs below would infer latches.
      nxt_sec   = sec + 6'd1;
      nxt_min   = minute;
      nxt_hour  = hour;
      nxt_day   = day;
      nxt_month = month;
      nxt_year  = year;
      if (sec == 6'd59) begin
         nxt_sec = '0;
         nxt_min = minute + 6'd1;
         if (minute == 6'd59) begin
            nxt_min  = '0;
            nxt_hour = hour + 5'd1;
            if (hour == 5'd23) begin
               nxt_hour = '0;
               nxt_day  = day + 5'd1;
               if (day == cur_mlen) begin
                  nxt_day   = 5'd1;
                  nxt_month = month + 4'd1;
                  if (month == 4'd12) begin
                     nxt_month = 4'd1;
                     nxt_year  = year + 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sec       <= '0;
         minute    <= '0;
         hour      <= '0;
         day       <= 5'd1;
         month     <= 4'd1;
         year      <= '0;
         tick_1hz  <= 1'b0;
         set_err   <= 1'b0;
         alarm_irq <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of the others, independent of statement order.
         tick_1hz  <= 1'b0;
         set_err   <= 1'b0;
         // tick_1hz is only ever set by a tick-driven advance, so loads cannot fire the alarm.
         alarm_irq <= tick_1hz && alarm_en && alarm_match;
         if (set_en && set_valid) begin
            cnt    <= '0;
            sec    <= set_sec;
            minute <= set_min;
            hour   <= set_hour;
            day    <= set_day;
            month  <= set_month;
            year   <= set_year;
         end else begin
            set_err <= set_en;
            if (tick) begin
               cnt      <= '0;
               tick_1hz <= 1'b1;
               sec      <= nxt_sec;
               minute   <= nxt_min;
               hour     <= nxt_hour;
               day      <= nxt_day;
               month    <= nxt_month;
               year     <= nxt_year;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar with PRESCALE=4: reset, rollovers, leap
// years, load validation, load/tick collision and alarm behaviour.
module tb_rtc_calendar;

   localparam int YW = 7;

   logic          clk;
   logic          rst_n;
   logic          set_en;
   logic [5:0]    set_sec;
   logic [5:0]    set_min;
   logic [4:0]    set_hour;
   logic [4:0]    set_day;
   logic [3:0]    set_month;
   logic [YW-1:0] set_year;
   logic          alarm_en;
   logic [5:0]    alarm_sec;
   logic [5:0]    alarm_min;
   logic [4:0]    alarm_hour;
   logic [5:0]    sec;
   logic [5:0]    minute;
   logic [4:0]    hour;
   logic [4:0]    day;
   logic [3:0]    month;
   logic [YW-1:0] year;
   logic          tick_1hz;
   logic          set_err;
   logic          alarm_irq;

   int n_checks  = 0;
   int n_fail    = 0;
   int alarm_cnt = 0;

   rtc_calendar #(
      .PRESCALE  (4),
      .YEAR_BASE (2000),
      .YEAR_WIDTH(YW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (set_en),
      .set_sec   (set_sec),
      .set_min   (set_min),
      .set_hour  (set_hour),
      .set_day   (set_day),
      .set_month (set_month),
      .set_year  (set_year),
      .alarm_en  (alarm_en),
      .alarm_sec (alarm_sec),
      .alarm_min (alarm_min),
      .alarm_hour(alarm_hour),
      .sec       (sec),
      .minute    (minute),
      .hour      (hour),
      .day       (day),
      .month     (month),
      .year      (year),
      .tick_1hz  (tick_1hz),
      .set_err   (set_err),
      .alarm_irq (alarm_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) if (rst_n && alarm_irq) alarm_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_time(input string tag, input int h, input int m, input int s,
                             input int d, input int mo, input int y);
      check({tag, "_hour"},   32'(hour),   32'(h));
      check({tag, "_minute"}, 32'(minute), 32'(m));
      check({tag, "_sec"},    32'(sec),    32'(s));
      check({tag, "_day"},    32'(day),    32'(d));
      check({tag, "_month"},  32'(month),  32'(mo));
      check({tag, "_year"},   32'(year),   32'(y));
   endtask

   // Returns at the negedge where tick_1hz is seen; cycles = negedges waited.
   task automatic wait_tick(input string tag, output int cycles);
      logic seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < 16) begin
         @(negedge clk);
         cycles++;
         seen = tick_1hz;
      end
      if (!seen) check({tag, "_tick_timeout"}, 32'(seen), 32'd1);
   endtask

   // Drives set_en for one edge; returns at the negedge after the load edge.
   task automatic do_load(input int h, input int m, input int s,
                          input int d, input int mo, input int y);
      set_hour  = 5'(h);
      set_min   = 6'(m);
      set_sec   = 6'(s);
      set_day   = 5'(d);
      set_month = 4'(mo);
      set_year  = YW'(y);
      set_en    = 1'b1;
      @(negedge clk);
      set_en    = 1'b0;
   endtask

   initial begin
      int n;
      int base;
      rst_n      = 1'b1;
      set_en     = 1'b0;
      set_sec    = '0;
      set_min    = '0;
      set_hour   = '0;
      set_day    = 5'd1;
      set_month  = 4'd1;
      set_year   = '0;
      alarm_en   = 1'b1;
      alarm_hour = 5'd0;
      alarm_min  = 6'd0;
      alarm_sec  = 6'd5;
      #2 rst_n = 1'b0;

      // Reset state
      @(negedge clk);
      check_time("reset", 0, 0, 0, 1, 1, 0);
      check("reset_tick", 32'(tick_1hz), 0);
      check("reset_set_err", 32'(set_err), 0);
      check("reset_alarm", 32'(alarm_irq), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Prescaler: first tick 4 cycles after release, then every 4 cycles
      wait_tick("first", n);
      check("first_tick_latency", 32'(n), 4);
      check("sec_after_1", 32'(sec), 1);
      wait_tick("second", n);
      check("tick_period", 32'(n), 4);
      repeat (3) wait_tick("run5", n);
      check("sec_at_5", 32'(sec), 5);
      check("alarm_not_yet", 32'(alarm_irq), 0);
      @(negedge clk);
      check("alarm_fires", 32'(alarm_irq), 1);
      @(negedge clk);
      check("alarm_one_cycle", 32'(alarm_irq), 0);

      repeat (55) wait_tick("run60", n);
      check_time("after_60", 0, 1, 0, 1, 1, 0);
      repeat (3540) wait_tick("run3600", n);
      check_time("after_3600", 1, 0, 0, 1, 1, 0);
      check("alarm_once", 32'(alarm_cnt), 1);

      // Leap-year rollovers
      do_load(23, 59, 59, 28, 2, 24);
      check("load_no_err", 32'(set_err), 0);
      check("load_no_tick", 32'(tick_1hz), 0);
      check_time("load_2024", 23, 59, 59, 28, 2, 24);
      wait_tick("leap2024", n);
      check("load_restart_period", 32'(n), 4);
      check_time("leap2024", 0, 0, 0, 29, 2, 24);

      do_load(23, 59, 59, 28, 2, 23);
      wait_tick("nonleap2023", n);
      check_time("nonleap2023", 0, 0, 0, 1, 3, 23);

      do_load(23, 59, 59, 28, 2, 100);
      wait_tick("nonleap2100", n);
      check_time("nonleap2100", 0, 0, 0, 1, 3, 100);

      do_load(23, 59, 59, 28, 2, 0);
      wait_tick("leap2000", n);
      check_time("leap2000", 0, 0, 0, 29, 2, 0);

      do_load(23, 59, 59, 31, 12, 127);
      wait_tick("year_wrap", n);
      check_time("year_wrap", 0, 0, 0, 1, 1, 0);

      // Invalid loads: no state change, prescaler keeps running
      do_load(0, 0, 0, 31, 4, 0);
      check("apr31_err", 32'(set_err), 1);
      check_time("apr31", 0, 0, 0, 1, 1, 0);
      @(negedge clk);
      check("set_err_one_cycle", 32'(set_err), 0);
      wait_tick("after_apr31", n);
      check("invalid_keeps_prescaler", 32'(n), 2);
      check("sec_after_apr31", 32'(sec), 1);

      do_load(0, 0, 0, 29, 2, 23);
      check("feb29_2023_err", 32'(set_err), 1);
      check_time("feb29_2023", 0, 0, 1, 1, 1, 0);
      wait_tick("after_feb29", n);
      check("sec_after_feb29", 32'(sec), 2);

      do_load(24, 0, 0, 1, 1, 0);
      check("hour24_err", 32'(set_err), 1);
      check_time("hour24", 0, 0, 2, 1, 1, 0);
      wait_tick("after_hour24", n);
      check("sec_after_hour24", 32'(sec), 3);

      // Invalid load coinciding with a tick: the tick still advances time
      repeat (3) @(negedge clk);
      do_load(0, 0, 0, 31, 4, 0);
      check("inv_tick_err", 32'(set_err), 1);
      check("inv_tick_tick", 32'(tick_1hz), 1);
      check("inv_tick_sec", 32'(sec), 4);

      // Valid load in the tick cycle: load wins, tick suppressed
      repeat (3) @(negedge clk);
      do_load(10, 0, 0, 1, 1, 0);
      check("collide_no_tick", 32'(tick_1hz), 0);
      check("collide_no_err", 32'(set_err), 0);
      check_time("collide", 10, 0, 0, 1, 1, 0);
      wait_tick("after_collide", n);
      check("collide_restart", 32'(n), 4);
      check("collide_sec", 32'(sec), 1);

      // Loading the alarm time never fires the alarm
      base = alarm_cnt;
      do_load(0, 0, 5, 1, 1, 0);
      check("load_alarm_time_a", 32'(alarm_irq), 0);
      @(negedge clk);
      check("load_alarm_time_b", 32'(alarm_irq), 0);
      @(negedge clk);
      check("load_alarm_count", 32'(alarm_cnt), 32'(base));

      // Disabled alarm: matching tick produces no pulse
      alarm_en = 1'b0;
      do_load(0, 0, 4, 1, 1, 0);
      wait_tick("alarm_dis", n);
      check("alarm_dis_sec", 32'(sec), 5);
      @(negedge clk);
      check("alarm_dis_irq", 32'(alarm_irq), 0);
      check("alarm_dis_count", 32'(alarm_cnt), 32'(base));

      // Re-enabled alarm fires again one cycle after the matching tick
      alarm_en = 1'b1;
      do_load(0, 0, 4, 1, 1, 0);
      wait_tick("alarm_re", n);
      check("alarm_re_pre", 32'(alarm_irq), 0);
      @(negedge clk);
      check("alarm_re_irq", 32'(alarm_irq), 1);

      // Asynchronous reset mid-operation
      do_load(13, 27, 41, 15, 6, 50);
      #2 rst_n = 1'b0;
      #1;
      check_time("async_reset", 0, 0, 0, 1, 1, 0);
      check("async_reset_tick", 32'(tick_1hz), 0);
      #2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
